// File: rtl/cache_array_pkg.sv
// Shared types and defaults for the cache way array and the cache controllers.
package cache_array_pkg;

  localparam int DEF_S_INDEX = 5;
  localparam int DEF_WIDTH   = 24;
  localparam int DEF_WAYS    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  function automatic int way_lsb(input int way, input int width);
    return way * width;
  endfunction

endpackage

// File: rtl/cache_way_array_if.sv
// Controller-side bus of the cache way array: read/write request, flush request, read data and busy.
interface cache_way_array_if #(
  parameter int S_INDEX = cache_array_pkg::DEF_S_INDEX,
  parameter int WIDTH   = cache_array_pkg::DEF_WIDTH,
  parameter int WAYS    = cache_array_pkg::DEF_WAYS
);

  logic                    read;
  logic [WAYS-1:0]         load;
  logic [S_INDEX-1:0]      rindex;
  logic [S_INDEX-1:0]      windex;
  logic [WIDTH-1:0]        datain;
  logic [WIDTH-1:0]        wmask;
  logic                    flush_req;
  logic [WAYS*WIDTH-1:0]   dataout;
  logic                    busy;

  modport master (
    output read, load, rindex, windex, datain, wmask, flush_req,
    input  dataout, busy
  );

  modport slave (
    input  read, load, rindex, windex, datain, wmask, flush_req,
    output dataout, busy
  );

endinterface

// File: rtl/cache_way_bank.sv
// One way of the cache array: per-set storage, bit-masked write, write-first bypass and read register.
module cache_way_bank #(
  parameter int S_INDEX = cache_array_pkg::DEF_S_INDEX,
  parameter int WIDTH   = cache_array_pkg::DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic               load,
  input  logic [S_INDEX-1:0] rindex,
  input  logic [S_INDEX-1:0] windex,
  input  logic [WIDTH-1:0]   datain,
  input  logic [WIDTH-1:0]   wmask,
  input  logic               flush_clr,
  input  logic [S_INDEX-1:0] flush_idx,
  output logic [WIDTH-1:0]   dataout
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  logic [WIDTH-1:0] mem [NUM_SETS];
  logic [WIDTH-1:0] merged_p0;
  logic             bypass_p0;
  logic [WIDTH-1:0] rd_data_p1;

  function automatic logic [WIDTH-1:0] mask_merge(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] new_v,
                                                  input logic [WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Stage p0: combinational merge of incoming write with the stored entry
  assign merged_p0 = mask_merge(mem[windex], datain, wmask);
  assign bypass_p0 = load && (rindex == windex);

  // Stage p0 -> p1: storage update and read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        mem[i] <= '0;
      end
      rd_data_p1 <= '0;
    end else begin
      if (flush_clr) begin
        mem[flush_idx] <= '0;
      end else if (load) begin
        mem[windex] <= merged_p0;
      end
      if (read) begin
        if (flush_clr) begin
          rd_data_p1 <= '0;
        end else if (bypass_p0) begin
          rd_data_p1 <= merged_p0;
        end else begin
          rd_data_p1 <= mem[rindex];
        end
      end
    end
  end

  assign dataout = rd_data_p1;

endmodule

// File: rtl/cache_way_array.sv
// N-way cache tag/state array with per-way masked writes and a one-set-per-cycle flush engine.
module cache_way_array
  import cache_array_pkg::*;
#(
  parameter int S_INDEX = DEF_S_INDEX,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int WAYS    = DEF_WAYS
) (
  input logic               clk,
  input logic               rst,
  cache_way_array_if.slave  bus
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

  flush_state_t       state;
  logic [S_INDEX-1:0] flush_cnt;
  logic               busy_q;
  logic               flush_active;
  logic [WIDTH-1:0]   rd_way [WAYS];

  assign flush_active = (state == FLUSH);

  // Flush FSM: busy rises on the accepting edge and falls on the edge clearing the last set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == LAST_SET) begin
            state     <= IDLE;
            flush_cnt <= '0;
            busy_q    <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + S_INDEX'(1);
          end
        end
        default: begin
          state     <= IDLE;
          flush_cnt <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_bank #(
      .S_INDEX (S_INDEX),
      .WIDTH   (WIDTH)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .read      (bus.read),
      .load      (bus.load[w]),
      .rindex    (bus.rindex),
      .windex    (bus.windex),
      .datain    (bus.datain),
      .wmask     (bus.wmask),
      .flush_clr (flush_active),
      .flush_idx (flush_cnt),
      .dataout   (rd_way[w])
    );

    assign bus.dataout[way_lsb(w, WIDTH) +: WIDTH] = rd_way[w];
  end

endmodule

// File: tb/tb_cache_way_array.sv
// Scoreboard bench for cache_way_array: directed reads push expected data, a monitor checks each captured read.
module tb_cache_way_array;

  localparam int S_INDEX = 5;
  localparam int WIDTH   = 24;
  localparam int WAYS    = 2;
  localparam int DW      = WAYS * WIDTH;
  localparam int NSETS   = 2 ** S_INDEX;

  typedef struct {
    logic [DW-1:0] v;
    string         nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  exp_t exp_q[$];
  logic rd_cap;

  cache_way_array_if #(.S_INDEX(S_INDEX), .WIDTH(WIDTH), .WAYS(WAYS)) bus ();

  cache_way_array #(.S_INDEX(S_INDEX), .WIDTH(WIDTH), .WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  // Applies one cycle of inputs; a read also queues the data expected after the next edge
  task automatic apply(input logic rd, input logic [WAYS-1:0] ld,
                       input logic [S_INDEX-1:0] ri, input logic [S_INDEX-1:0] wi,
                       input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] wm,
                       input logic fr, input logic [DW-1:0] ev, input string nm);
    exp_t e;
    bus.read      = rd;
    bus.load      = ld;
    bus.rindex    = ri;
    bus.windex    = wi;
    bus.datain    = di;
    bus.wmask     = wm;
    bus.flush_req = fr;
    if (rd) begin
      e.v  = ev;
      e.nm = nm;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input logic rd, input logic [WAYS-1:0] ld,
                      input logic [S_INDEX-1:0] ri, input logic [S_INDEX-1:0] wi,
                      input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] wm,
                      input logic fr, input logic [DW-1:0] ev, input string nm);
    @(negedge clk);
    apply(rd, ld, ri, wi, di, wm, fr, ev, nm);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, '0, "");
  endtask

  // Monitor: a read accepted at a posedge is checked at the following negedge
  always @(posedge clk or posedge rst) begin
    if (rst) rd_cap <= 1'b0;
    else     rd_cap <= bus.read;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rd_cap) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_read: got %h expected no output", bus.dataout);
      end else begin
        e = exp_q.pop_front();
        check(e.nm, bus.dataout, e.v);
      end
    end
  end

  // Counts busy cycles after a flush has been requested; optional reset abort at abort_at
  task automatic run_flush(input int abort_at, output int cycles);
    int c;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      c++;
      apply(1'b0, '0, '0, '0, '0, '0, 1'b0, '0, "");
      if (abort_at == 0) begin
        if (c == 5)  apply(1'b0, '0, '0, '0, '0, '0, 1'b1, '0, "");
        if (c == 8)  apply(1'b0, 2'b10, '0, 5'd0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, '0, "");
        if (c == 10) apply(1'b1, '0, 5'd31, '0, '0, '0, 1'b0, '0, "read_in_flush");
      end else if (c == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_busy", DW'(bus.busy), '0);
        check("abort_dataout", bus.dataout, '0);
        break;
      end
    end
    cycles = c;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    apply(1'b0, '0, '0, '0, '0, '0, 1'b0, '0, "");
    repeat (2) @(negedge clk);
    check("reset_busy", DW'(bus.busy), '0);
    check("reset_dataout", bus.dataout, '0);
    rst = 1'b0;

    step(1'b1, '0, 5'd3, '0, '0, '0, 1'b0, '0, "rst_read");
    step(1'b0, 2'b10, '0, 5'd7, 24'hABCDEF, 24'hFFFFFF, 1'b0, '0, "");
    step(1'b1, '0, 5'd7, '0, '0, '0, 1'b0, {24'hABCDEF, 24'h000000}, "wr_full");
    step(1'b0, 2'b10, '0, 5'd7, 24'h000000, 24'h00000F, 1'b0, '0, "");
    step(1'b1, '0, 5'd7, '0, '0, '0, 1'b0, {24'hABCDE0, 24'h000000}, "wr_mask");
    step(1'b1, 2'b01, 5'd2, 5'd2, 24'h123456, 24'hFFFFFF, 1'b0, {24'h000000, 24'h123456}, "bypass");
    step(1'b1, '0, 5'd2, '0, '0, '0, 1'b0, {24'h000000, 24'h123456}, "bypass_held");
    idle();
    idle();
    idle();
    check("read0_hold", bus.dataout, {24'h000000, 24'h123456});
    step(1'b0, 2'b01, '0, 5'd2, 24'hFFFFFF, 24'h000000, 1'b0, '0, "");
    step(1'b1, '0, 5'd2, '0, '0, '0, 1'b0, {24'h000000, 24'h123456}, "wmask_zero");
    step(1'b1, 2'b10, 5'd5, 5'd5, 24'h111111, 24'hFFFFFF, 1'b0, {24'h111111, 24'h000000}, "no_bypass_way0");
    step(1'b0, 2'b11, '0, 5'd9, 24'hA5A5A5, 24'hFFFFFF, 1'b0, '0, "");
    step(1'b1, '0, 5'd9, '0, '0, '0, 1'b0, {24'hA5A5A5, 24'hA5A5A5}, "multi_way");

    for (int s = 0; s < NSETS; s++)
      step(1'b0, 2'b11, '0, S_INDEX'(s), 24'h5A0000 | 24'(s), 24'hFFFFFF, 1'b0, '0, "");
    step(1'b1, '0, 5'd31, '0, '0, '0, 1'b0, {24'h5A001F, 24'h5A001F}, "fill_31");
    step(1'b0, 2'b01, '0, 5'd3, 24'h777777, 24'hFFFFFF, 1'b1, '0, "");
    run_flush(0, n);
    check("flush_len", DW'(n), DW'(NSETS));
    for (int s = 0; s < NSETS; s++)
      step(1'b1, '0, S_INDEX'(s), '0, '0, '0, 1'b0, '0, "flushed_set");
    idle();
    idle();

    step(1'b0, 2'b11, '0, 5'd20, 24'h444444, 24'hFFFFFF, 1'b0, '0, "");
    step(1'b1, '0, 5'd20, '0, '0, '0, 1'b0, {24'h444444, 24'h444444}, "refill_20");
    step(1'b0, '0, '0, '0, '0, '0, 1'b1, '0, "");
    run_flush(10, n);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, '0, 5'd20, '0, '0, '0, 1'b0, '0, "abort_entry_cleared");
    idle();
    check("abort_idle_busy", DW'(bus.busy), '0);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1, '0, "");
    run_flush(-1, n);
    check("flush_after_reset_len", DW'(n), DW'(NSETS));
    idle();
    idle();
    check("queue_drained", DW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
